// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-memory bus for mem_access_unit.
// slave = the access unit; master = the MEM stage plus the memory that answers it.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_write_data, mem_read, mem_write
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a big-endian, edge-strobed word memory.
// Sub-word stores are performed as read-modify-write.
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 2048
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_SETUP, RD_STROBE, RD_LATCH, MERGE,
    WR_SETUP, WR_STROBE, WR_HOLD, DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_t;

  state_t      state, state_next;
  op_t         op_q, req_op;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] addr_q;
  logic [31:0] wr_data_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_err;
  logic        misaligned;
  logic [2:0]  size;
  logic [32:0] last_byte;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_op = op_t'(bus.req_op);
  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    size       = 3'd1;
    misaligned = 1'b0;
    case (req_op)
      OP_LW, OP_SW: begin
        size       = 3'd4;
        misaligned = (bus.req_addr[1:0] != 2'b00);
      end
      OP_LH, OP_LHU, OP_SH: begin
        size       = 3'd2;
        misaligned = bus.req_addr[0];
      end
      default: ;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap below the limit
    last_byte = {1'b0, bus.req_addr} + {30'd0, size} - 33'd1;
    req_err   = misaligned || (last_byte >= 33'(ADDR_LIMIT));
  end

  always_comb begin
    byte_lane = bus.mem_data[31:24];
    case (off_q)
      2'd1:    byte_lane = bus.mem_data[23:16];
      2'd2:    byte_lane = bus.mem_data[15:8];
      2'd3:    byte_lane = bus.mem_data[7:0];
      default: ;
    endcase
    half_lane = off_q[1] ? bus.mem_data[15:0] : bus.mem_data[31:16];
    case (op_q)
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'd0, half_lane};
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'd0, byte_lane};
      default: load_val = bus.mem_data;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (op_q == OP_SB) begin
      case (off_q)
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[15:0] = wdata_q;
    end else begin
      merged[31:16] = wdata_q;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err)              state_next = DONE;
          else if (req_op == OP_SW) state_next = WR_SETUP;
          else                      state_next = RD_SETUP;
        end
      end
      RD_SETUP:  state_next = RD_STROBE;
      RD_STROBE: state_next = RD_LATCH;
      RD_LATCH:  state_next = (op_q == OP_SH || op_q == OP_SB) ? MERGE : DONE;
      MERGE:     state_next = WR_SETUP;
      WR_SETUP:  state_next = WR_STROBE;
      WR_STROBE: state_next = WR_HOLD;
      WR_HOLD:   state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_LW;
      off_q     <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q    <= req_op;
        off_q   <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata[15:0];
        addr_q  <= {bus.req_addr[31:2], 2'b00};
        if (req_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else if (req_op == OP_SW) begin
          wr_data_q <= bus.req_wdata;
        end
      end
      // Loads finish straight from the returned word; stores keep it for the merge
      if (state == RD_LATCH) begin
        if (op_q == OP_SH || op_q == OP_SB) begin
          word_q <= bus.mem_data;
        end else begin
          rdata_q <= load_val;
          err_q   <= 1'b0;
        end
      end
      if (state == MERGE) wr_data_q <= merged;
      if (state == WR_HOLD) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.req_ready      = (state == IDLE);
  assign bus.resp_valid     = (state == DONE);
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_err       = err_q;
  assign bus.mem_read       = (state == RD_STROBE);
  assign bus.mem_write      = (state == WR_STROBE);
  assign bus.mem_address    = addr_q;
  assign bus.mem_write_data = wr_data_q;

endmodule
